// File: rtl/winograd_input_loader.sv
// rtl/winograd_input_loader.sv - assembles a 3x3 kernel + 10x12 image frame from a 16-bit stream for the Winograd stage
// Optional build macro WINO_KERNEL_REUSE_EN lets a frame skip the kernel and keep the previously loaded one.
module winograd_input_loader (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic [15:0] kernel_out [0:2][0:2],
  output logic [15:0] image_out  [0:9][0:11],
  output logic        conv_start,
  input  logic        conv_done,
  output logic        busy,
  output logic        frame_err
`ifdef WINO_KERNEL_REUSE_EN
  ,
  input  logic        reuse_kernel
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KERNEL,
    ST_IMAGE,
    ST_START,
    ST_WAIT_CONV
  } state_t;

  state_t     state;
  state_t     state_nxt;
  state_t     load_state;
  logic [3:0] k;
  logic [3:0] row;
  logic [3:0] col;
  logic [1:0] k_row;
  logic [1:0] k_col;
  logic       accept;
  logic       kernel_end;
  logic       image_end;
  logic       in_ready_nxt;
  logic       conv_start_nxt;
  logic       busy_nxt;
  logic       frame_err_nxt;

  assign accept     = in_valid && in_ready;
  assign kernel_end = (k == 4'd8);
  assign image_end  = (row == 4'd9) && (col == 4'd11);

`ifdef WINO_KERNEL_REUSE_EN
  logic kernel_loaded;

  // Entry point of the next load phase; reuse only makes sense once a kernel has fully arrived.
  assign load_state = (reuse_kernel && kernel_loaded) ? ST_IMAGE : ST_KERNEL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kernel_loaded <= 1'b0;
    end else if (state == ST_KERNEL && accept && kernel_end) begin
      kernel_loaded <= 1'b1;
    end
  end
`else
  assign load_state = ST_KERNEL;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      in_ready   <= 1'b0;
      conv_start <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      in_ready   <= in_ready_nxt;
      conv_start <= conv_start_nxt;
      busy       <= busy_nxt;
      frame_err  <= frame_err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: state_nxt = load_state;
      ST_KERNEL: begin
        if (accept) begin
          if (in_last)         state_nxt = load_state;
          else if (kernel_end) state_nxt = ST_IMAGE;
        end
      end
      ST_IMAGE: begin
        if (accept) begin
          if (image_end && in_last)    state_nxt = ST_START;
          else if (image_end || in_last) state_nxt = load_state;
        end
      end
      ST_START:     state_nxt = ST_WAIT_CONV;
      ST_WAIT_CONV: if (conv_done) state_nxt = load_state;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    in_ready_nxt   = (state_nxt == ST_KERNEL) || (state_nxt == ST_IMAGE);
    busy_nxt       = (state_nxt == ST_START) || (state_nxt == ST_WAIT_CONV);
    conv_start_nxt = (state_nxt == ST_START);
    frame_err_nxt  = accept &&
                     (((state == ST_KERNEL) && in_last) ||
                      ((state == ST_IMAGE) && (in_last != image_end)));
  end

  always_comb begin
    k_row = 2'd0;
    k_col = 2'd0;
    case (k)
      4'd1: k_col = 2'd1;
      4'd2: k_col = 2'd2;
      4'd3: k_row = 2'd1;
      4'd4: begin k_row = 2'd1; k_col = 2'd1; end
      4'd5: begin k_row = 2'd1; k_col = 2'd2; end
      4'd6: k_row = 2'd2;
      4'd7: begin k_row = 2'd2; k_col = 2'd1; end
      4'd8: begin k_row = 2'd2; k_col = 2'd2; end
      default: begin k_row = 2'd0; k_col = 2'd0; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k   <= 4'd0;
      row <= 4'd0;
      col <= 4'd0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          kernel_out[r][c] <= 16'd0;
      for (int r = 0; r < 10; r++)
        for (int c = 0; c < 12; c++)
          image_out[r][c] <= 16'd0;
    end else begin
      if (state == ST_KERNEL && accept) begin
        kernel_out[k_row][k_col] <= in_data;
        row <= 4'd0;
        col <= 4'd0;
        if (in_last || kernel_end) k <= 4'd0;
        else                       k <= k + 4'd1;
      end
      // Any terminating word (good or bad) rewinds the image position for the next frame.
      if (state == ST_IMAGE && accept) begin
        image_out[row][col] <= in_data;
        if (in_last || image_end) begin
          row <= 4'd0;
          col <= 4'd0;
        end else if (col == 4'd11) begin
          col <= 4'd0;
          row <= row + 4'd1;
        end else begin
          col <= col + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_winograd_input_loader.sv
// tb/tb_winograd_input_loader.sv - self-checking bench for winograd_input_loader
// Define WINO_KERNEL_REUSE_EN to also exercise kernel reuse.
module tb_winograd_input_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic [15:0] kernel_out [0:2][0:2];
  logic [15:0] image_out  [0:9][0:11];
  logic        conv_start;
  logic        conv_done;
  logic        busy;
  logic        frame_err;
`ifdef WINO_KERNEL_REUSE_EN
  logic        reuse_kernel;
`endif

  winograd_input_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .kernel_out (kernel_out),
    .image_out  (image_out),
    .conv_start (conv_start),
    .conv_done  (conv_done),
    .busy       (busy),
    .frame_err  (frame_err)
`ifdef WINO_KERNEL_REUSE_EN
    ,
    .reuse_kernel (reuse_kernel)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;
  int err_cnt = 0;

  // Reference frame contents as flat row-major vectors.
  logic [15:0] exp_k [9];
  logic [15:0] exp_i [120];

  always @(negedge clk) begin
    if (conv_start) start_cnt++;
    if (frame_err)  err_cnt++;
  end

  task automatic send_word(input logic [15:0] d, input logic l, input int gap, output bit ok);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // nk kernel words (9 or 0) then image words; count words sent, in_last on word last_pos.
  task automatic send_frame(input int nk, input int count, input int last_pos,
                            input int gap_mode, input bit rand_data, input bit noisy_done);
    logic [15:0] d;
    int gap;
    bit ok;
    bit all_ok;
    all_ok = 1'b1;
    for (int p = 0; p < count; p++) begin
      if (rand_data)   d = 16'($urandom_range(0, 65535));
      else if (p < nk) d = 16'(p + 1);
      else             d = 16'(p - nk + 100);
      case (gap_mode)
        1:       gap = 1;
        2:       gap = $urandom_range(0, 2);
        default: gap = 0;
      endcase
      if (noisy_done) conv_done = 1'($urandom_range(0, 1));
      send_word(d, (p == last_pos), gap, ok);
      if (!ok) all_ok = 1'b0;
      if (p < nk) exp_k[p] = d;
      else        exp_i[p - nk] = d;
    end
    conv_done = 1'b0;
    checks++;
    if (!all_ok) begin
      errors++;
      $display("FAIL word_accept_timeout: got in_ready stuck low expected all %0d words accepted", count);
    end
  endtask

  // Called at the negedge of the cycle right after word 119 was accepted.
  task automatic finish_frame(input int latency);
    int bad;
    checks++;
    if (conv_start !== 1'b1) begin errors++; $display("FAIL start_pulse: got %b expected 1", conv_start); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_in_start: got %b expected 1", busy); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL ready_in_start: got %b expected 0", in_ready); end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL err_on_good_frame: got %b expected 0", frame_err); end
    @(negedge clk);
    checks++;
    if (conv_start !== 1'b0) begin errors++; $display("FAIL start_width: got %b expected 0", conv_start); end
    bad = 0;
    for (int t = 0; t < latency; t++) begin
      if (in_ready !== 1'b0 || busy !== 1'b1 || conv_start !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL wait_conv_hold: got %0d bad cycles expected 0", bad); end
    conv_done = 1'b1;
    @(negedge clk);
    conv_done = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("FAIL ready_after_done: got ready=%b busy=%b expected ready=1 busy=0", in_ready, busy); end
    bad = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (kernel_out[r][c] !== exp_k[r*3 + c]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL kernel_array: got %0d wrong entries expected 0", bad); end
    bad = 0;
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 12; c++)
        if (image_out[r][c] !== exp_i[r*12 + c]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL image_array: got %0d wrong entries expected 0", bad); end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL ready_idle_cycle: got %b expected 0", in_ready); end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_second_cycle: got %b expected 1", in_ready); end
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 16'd0; in_last = 1'b0; conv_done = 1'b0;
`ifdef WINO_KERNEL_REUSE_EN
    reuse_kernel = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, conv_start, busy, frame_err} !== 4'b0000)
      begin errors++; $display("FAIL reset_outputs: got %b expected 0000", {in_ready, conv_start, busy, frame_err}); end
    bad = 0;
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 12; c++)
        if (image_out[r][c] !== 16'd0 || kernel_out[r % 3][c % 3] !== 16'd0) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL reset_arrays: got %0d nonzero expected 0", bad); end
    release_reset();
  endtask

  task automatic test_clean_frame();
    int s;
    s = start_cnt;
    send_frame(9, 129, 128, 0, 1'b0, 1'b0);
    finish_frame(5);
    checks++;
    if (kernel_out[2][1] !== 16'd8) begin errors++; $display("FAIL kernel_2_1: got %0d expected 8", kernel_out[2][1]); end
    checks++;
    if (image_out[9][11] !== 16'd219) begin errors++; $display("FAIL image_9_11: got %0d expected 219", image_out[9][11]); end
    checks++;
    if (start_cnt != s + 1) begin errors++; $display("FAIL start_count: got %0d expected %0d", start_cnt - s, 1); end
  endtask

  task automatic test_stalls();
    send_frame(9, 129, 128, 1, 1'b0, 1'b0);
    finish_frame(2);
    send_frame(9, 129, 128, 2, 1'b1, 1'b1);
    finish_frame($urandom_range(0, 8));
  endtask

  task automatic test_early_last();
    int s, e;
    s = start_cnt;
    e = err_cnt;
    for (int n = 0; n < 2; n++) begin
      send_frame(9, (n == 0) ? 60 : 5, (n == 0) ? 59 : 4, 0, 1'b1, 1'b0);
      checks++;
      if (frame_err !== 1'b1 || in_ready !== 1'b1 || conv_start !== 1'b0)
        begin errors++; $display("FAIL early_last_pulse: got err=%b ready=%b start=%b expected 1 1 0", frame_err, in_ready, conv_start); end
      @(negedge clk);
      checks++;
      if (frame_err !== 1'b0) begin errors++; $display("FAIL early_last_width: got %b expected 0", frame_err); end
    end
    send_frame(9, 129, 128, 0, 1'b1, 1'b0);
    finish_frame(3);
    checks++;
    if (start_cnt != s + 1 || err_cnt != e + 2)
      begin errors++; $display("FAIL early_last_counts: got starts=%0d errs=%0d expected 1 2", start_cnt - s, err_cnt - e); end
  endtask

  task automatic test_missing_last();
    int s;
    s = start_cnt;
    send_frame(9, 129, -1, 0, 1'b1, 1'b0);
    checks++;
    if (frame_err !== 1'b1 || conv_start !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL missing_last: got err=%b start=%b ready=%b expected 1 0 1", frame_err, conv_start, in_ready); end
    repeat (3) @(negedge clk);
    checks++;
    if (start_cnt != s) begin errors++; $display("FAIL missing_last_start: got %0d starts expected 0", start_cnt - s); end
    send_frame(9, 129, 128, 0, 1'b1, 1'b0);
    finish_frame(1);
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    send_frame(9, 69, -1, 0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, conv_start, busy, frame_err} !== 4'b0000)
      begin errors++; $display("FAIL midframe_reset_outputs: got %b expected 0000", {in_ready, conv_start, busy, frame_err}); end
    bad = 0;
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 12; c++)
        if (image_out[r][c] !== 16'd0 || kernel_out[r % 3][c % 3] !== 16'd0) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL midframe_reset_arrays: got %0d nonzero expected 0", bad); end
    foreach (exp_k[i]) exp_k[i] = 16'd0;
    foreach (exp_i[i]) exp_i[i] = 16'd0;
    release_reset();
    send_frame(9, 129, 128, 0, 1'b1, 1'b0);
    finish_frame(4);
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      send_frame(9, 129, 128, (f == 1) ? 2 : 0, 1'b1, 1'b1);
      finish_frame($urandom_range(0, 6));
    end
  endtask

`ifdef WINO_KERNEL_REUSE_EN
  task automatic test_kernel_reuse();
    int s;
    send_frame(9, 129, 128, 0, 1'b1, 1'b0);
    reuse_kernel = 1'b1;
    finish_frame(2);
    reuse_kernel = 1'b0;
    s = start_cnt;
    send_frame(0, 120, 119, 0, 1'b1, 1'b0);
    finish_frame(2);
    checks++;
    if (start_cnt != s + 1) begin errors++; $display("FAIL reuse_start: got %0d starts expected 1", start_cnt - s); end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_frame();
    test_stalls();
    test_early_last();
    test_missing_last();
    test_reset_mid_frame();
    test_back_to_back();
`ifdef WINO_KERNEL_REUSE_EN
    test_kernel_reuse();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1);
  end

endmodule
